div_clock_monitor: RTL and testbench

- Receive-side companion to the on-chip clock divider.
- Samples a divided clock as data in the fast `clk` domain, detects its rising edges, and measures period and high time in `clk` cycles.
- Declares lock after a run of periods that match the expected ratio, and flags ratio errors and loss of clock.
- Sits beside the divider in the clock-manipulation area and gates downstream slow-domain logic via `locked`.

---
 rtl/clk_mon_pkg.sv | 16 +
 rtl/bit_synchronizer.sv | 33 +++
 rtl/div_clock_monitor.sv | 131 +++++++++++++
 tb/tb_div_clock_monitor.sv | 468 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_mon_pkg.sv
// Shared types and constants for the divided-clock monitor.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    LOCKED  = 2'd3
  } mon_state_e;

  // All-ones value of a counter of the given width; doubles as the saturation point.
  function automatic logic [31:0] CNT_MAX(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// Single-bit flop chain for bringing an asynchronous level into the clk domain.
module bit_synchronizer #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign q = d;
    end else if (STAGES == 1) begin : g_one
      logic ff;
      // NOTE: asynchronous reset in the sensitivity list, and <= for every
      // flop so all stages sample the pre-edge values together.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= 1'b0;
        else      ff <= d;
      end
      assign q = ff;
    end else begin : g_chain
      logic [STAGES-1:0] ff;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) ff <= '0;
        else      ff <= {ff[STAGES-2:0], d};
      end
      assign q = ff[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/div_clock_monitor.sv
// Measures period and high time of a divided clock sampled in the clk domain,
// declares ratio lock and flags ratio errors and loss of clock.
module div_clock_monitor
  import clk_mon_pkg::*;
#(
  parameter int unsigned EXP_PERIOD  = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned LOCK_CNT    = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clk_in,
  input  logic             err_clr,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             period_valid,
  output logic             locked,
  output logic             err,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(CNT_MAX(CNT_W));
  localparam logic [CNT_W-1:0] EXP_CNT  = CNT_W'(EXP_PERIOD);
  localparam logic [3:0]       LOCK_TGT = 4'(LOCK_CNT);

  mon_state_e       state, state_nxt;
  logic             s, s_d, rise;
  logic [CNT_W-1:0] cnt, hcnt;
  logic [3:0]       good_cnt;
  logic             measuring, meas, period_good, tmo, err_set;

  bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (clk_in),
    .q   (s)
  );

  assign rise        = s & ~s_d;
  assign measuring   = (state == MEASURE) || (state == LOCKED);
  assign meas        = en && measuring && rise;
  assign period_good = (cnt == EXP_CNT);
  // A rising edge on the saturation cycle is still a measurement, not a timeout.
  assign tmo         = en && measuring && !rise && (cnt == MAX_CNT);
  assign err_set     = (state == LOCKED) && ((meas && !period_good) || tmo);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = ARMED;
        ARMED:   if (rise) state_nxt = MEASURE;
        MEASURE: begin
          if (meas && period_good && (good_cnt + 4'd1 == LOCK_TGT)) state_nxt = LOCKED;
          else if (tmo)                                             state_nxt = ARMED;
        end
        LOCKED: begin
          if (meas && !period_good) state_nxt = MEASURE;
          else if (tmo)             state_nxt = ARMED;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    locked = (state == LOCKED);
  end

  // Period and high-time counters restart at 1 on each edge and saturate.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_d  <= 1'b0;
      cnt  <= '0;
      hcnt <= '0;
    end else begin
      s_d <= s;
      if (!en || state == IDLE) begin
        cnt  <= '0;
        hcnt <= '0;
      end else if (rise) begin
        cnt  <= CNT_W'(1);
        hcnt <= CNT_W'(1);
      end else begin
        if (cnt != MAX_CNT)       cnt  <= cnt + 1'b1;
        if (s && hcnt != MAX_CNT) hcnt <= hcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      good_cnt <= '0;
    end else if (!en || tmo || (meas && !period_good)) begin
      good_cnt <= '0;
    end else if (meas && state == MEASURE) begin
      good_cnt <= good_cnt + 4'd1;
    end
  end

  // Measurement results survive an enable drop; only reset clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period       <= '0;
      high_time    <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      err          <= 1'b0;
    end else begin
      period_valid <= meas;
      timeout      <= tmo;
      if (meas) begin
        period    <= cnt;
        high_time <= hcnt;
      end
      if (err_set)      err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_div_clock_monitor.sv
// Bench for div_clock_monitor: two instances (default and EXP_PERIOD=4 / one sync
// stage) checked every cycle against an event-level reference model.
module tb_div_clock_monitor;

  localparam int MAX      = 255;
  localparam int LOCK_CNT = 4;
  localparam int HIST     = 8192;

  typedef struct packed {
    logic       pv;
    logic       lk;
    logic       er;
    logic       to;
    logic [7:0] per;
    logic [7:0] hi;
  } out_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] en  = '0;
  logic [1:0] ci  = '0;
  logic [1:0] ec  = '0;

  logic [7:0] per0, hi0, per1, hi1;
  logic       pv0, lk0, er0, to0, pv1, lk1, er1, to1;
  out_t       obs [2];

  assign obs[0] = {pv0, lk0, er0, to0, per0, hi0};
  assign obs[1] = {pv1, lk1, er1, to1, per1, hi1};

  div_clock_monitor u_dut0 (
    .clk(clk), .rst(rst), .en(en[0]), .clk_in(ci[0]), .err_clr(ec[0]),
    .period(per0), .high_time(hi0), .period_valid(pv0),
    .locked(lk0), .err(er0), .timeout(to0)
  );

  div_clock_monitor #(.EXP_PERIOD(4), .SYNC_STAGES(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en[1]), .clk_in(ci[1]), .err_clr(ec[1]),
    .period(per1), .high_time(hi1), .period_valid(pv1),
    .locked(lk1), .err(er1), .timeout(to1)
  );

  always #5 clk = ~clk;

  // Reference model: edge times and high samples kept as history, period and
  // high time recomputed by arithmetic over that history.
  int   exp_per [2] = '{2, 4};
  int   sync_n  [2] = '{2, 1};
  bit   hist [2][HIST];
  int   t = 0;
  int   rst_t = 0;
  int   mode [2];          // 0 idle, 1 waiting for first edge, 2 measuring, 3 locked
  int   last_rise [2];
  int   good [2];
  out_t exp_o [2];
  int   errors = 0;
  int   checks = 0;

  function automatic int sval(int k, int tt);
    int idx = tt - sync_n[k];
    if (idx < rst_t) return 0;
    return int'(hist[k][idx]);
  endfunction

  function automatic int sat(int v);
    return (v > MAX) ? MAX : v;
  endfunction

  function automatic string fmt(out_t o);
    return $sformatf("pv=%b lk=%b err=%b to=%b period=%0d high=%0d",
                     o.pv, o.lk, o.er, o.to, o.per, o.hi);
  endfunction

  task automatic model_edge(input int k);
    int s, sd, per, hi;
    bit rise, set_err;
    hist[k][t] = ci[k];
    s  = sval(k, t);
    sd = sval(k, t - 1);
    rise = (s == 1) && (sd == 0);
    set_err = 1'b0;
    exp_o[k].pv = 1'b0;
    exp_o[k].to = 1'b0;
    if (!en[k]) begin
      mode[k] = 0;
      good[k] = 0;
    end else if (mode[k] == 0) begin
      mode[k] = 1;
    end else if (mode[k] == 1) begin
      if (rise) begin
        mode[k] = 2;
        last_rise[k] = t;
      end
    end else if (rise) begin
      per = sat(t - last_rise[k]);
      hi = 0;
      for (int j = last_rise[k]; j < t; j++) hi += sval(k, j);
      hi = sat(hi);
      exp_o[k].pv  = 1'b1;
      exp_o[k].per = 8'(per);
      exp_o[k].hi  = 8'(hi);
      last_rise[k] = t;
      if (per == exp_per[k]) begin
        if (mode[k] == 2) begin
          good[k]++;
          if (good[k] == LOCK_CNT) mode[k] = 3;
        end
      end else begin
        if (mode[k] == 3) set_err = 1'b1;
        good[k] = 0;
        mode[k] = 2;
      end
    end else if (t - last_rise[k] >= MAX) begin
      exp_o[k].to = 1'b1;
      if (mode[k] == 3) set_err = 1'b1;
      good[k] = 0;
      mode[k] = 1;
    end
    exp_o[k].lk = (mode[k] == 3);
    if (set_err)    exp_o[k].er = 1'b1;
    else if (ec[k]) exp_o[k].er = 1'b0;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input logic [1:0] c, input logic [1:0] e, input logic [1:0] x);
    ci = c;
    en = e;
    ec = x;
    @(posedge clk);
    if (t >= HIST) begin
      $display("FAIL history_overflow: step %0d exceeds %0d", t, HIST);
      $fatal(1);
    end
    model_edge(0);
    model_edge(1);
    t++;
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== out_t'(0)) begin
        errors++;
        $display("FAIL reset dut%0d: got %s, want all zero", k, fmt(obs[k]));
      end
    end
    for (int i = 0; i < 4; i++) begin
      step(2'(i & 1) | 2'b10, 2'b00, 2'b00);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_o[k]) begin
          errors++;
          $display("FAIL reset_idle dut%0d step %0d: got %s, want %s", k, t, fmt(obs[k]), fmt(exp_o[k]));
        end
      end
    end
    ci = '0;
    step(2'b00, 2'b00, 2'b00);
  endtask

  task automatic test_lock();
    int pv_seen = 0;
    int pv_at_lock = -1;
    for (int i = 0; i < 20; i++) begin
      step({1'b0, (i % 2 == 0)}, 2'b01, 2'b00);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_o[k]) begin
          errors++;
          $display("FAIL lock dut%0d step %0d: got %s, want %s", k, t, fmt(obs[k]), fmt(exp_o[k]));
        end
      end
      if (obs[0].pv) pv_seen++;
      if (obs[0].lk && pv_at_lock < 0) pv_at_lock = pv_seen;
    end
    checks++;
    if (pv_at_lock !== 4) begin
      errors++;
      $display("FAIL lock_after_4: pulses before lock=%0d want 4", pv_at_lock);
    end
    checks++;
    if ({obs[0].lk, obs[0].er, obs[0].per, obs[0].hi} !== {1'b1, 1'b0, 8'd2, 8'd1}) begin
      errors++;
      $display("FAIL lock_values: got %s, want lk=1 err=0 period=2 high=1", fmt(obs[0]));
    end
  endtask

  task automatic test_stretch();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      step({1'b0, (i % 2 == 0)}, 2'b01, 2'b00);
      checks++;
      if (obs[0] !== exp_o[0]) begin
        errors++;
        $display("FAIL stretch_pre step %0d: got %s, want %s", t, fmt(obs[0]), fmt(exp_o[0]));
      end
    end
    for (int i = 0; i < 6; i++) begin
      step({1'b0, pat[i]}, 2'b01, 2'b00);
      checks++;
      if (obs[0] !== exp_o[0]) begin
        errors++;
        $display("FAIL stretch step %0d: got %s, want %s", t, fmt(obs[0]), fmt(exp_o[0]));
      end
    end
    checks++;
    if ({obs[0].pv, obs[0].per, obs[0].er, obs[0].lk} !== {1'b1, 8'd3, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL stretch_detect: got %s, want pv=1 period=3 err=1 lk=0", fmt(obs[0]));
    end
    for (int i = 0; i < 10; i++) begin
      step({1'b0, (i % 2 == 1)}, 2'b01, 2'b00);
      checks++;
      if (obs[0] !== exp_o[0]) begin
        errors++;
        $display("FAIL stretch_relock step %0d: got %s, want %s", t, fmt(obs[0]), fmt(exp_o[0]));
      end
    end
    checks++;
    if ({obs[0].lk, obs[0].er} !== 2'b11) begin
      errors++;
      $display("FAIL stretch_relock_state: got %s, want lk=1 err=1", fmt(obs[0]));
    end
    step(2'b00, 2'b01, 2'b01);
    checks++;
    if (obs[0].er !== 1'b0 || obs[0] !== exp_o[0]) begin
      errors++;
      $display("FAIL err_clr: got %s, want %s", fmt(obs[0]), fmt(exp_o[0]));
    end
  endtask

  task automatic test_timeout();
    int last_pv = -1;
    int to_at = -1;
    int to_count = 0;
    int pv_seen = 0;
    int pv_at_lock = -1;
    for (int i = 0; i < 300; i++) begin
      step(2'b01, 2'b01, 2'b00);
      checks++;
      if (obs[0] !== exp_o[0]) begin
        errors++;
        $display("FAIL timeout step %0d: got %s, want %s", t, fmt(obs[0]), fmt(exp_o[0]));
      end
      if (obs[0].pv) last_pv = i;
      if (obs[0].to) begin
        to_count++;
        to_at = i;
      end
    end
    checks++;
    if (to_count !== 1 || to_at - last_pv !== 255) begin
      errors++;
      $display("FAIL timeout_once: pulses=%0d delay=%0d want 1 pulse after 255", to_count, to_at - last_pv);
    end
    checks++;
    if ({obs[0].er, obs[0].lk} !== 2'b10) begin
      errors++;
      $display("FAIL timeout_state: got %s, want err=1 lk=0", fmt(obs[0]));
    end
    for (int i = 0; i < 16; i++) begin
      step({1'b0, (i % 2 == 1)}, 2'b01, 2'b00);
      checks++;
      if (obs[0] !== exp_o[0]) begin
        errors++;
        $display("FAIL timeout_relock step %0d: got %s, want %s", t, fmt(obs[0]), fmt(exp_o[0]));
      end
      if (obs[0].pv) pv_seen++;
      if (obs[0].lk && pv_at_lock < 0) pv_at_lock = pv_seen;
    end
    checks++;
    if (pv_at_lock !== 4 || obs[0].er !== 1'b1) begin
      errors++;
      $display("FAIL timeout_relock_count: pulses before lock=%0d err=%b want 4 and 1", pv_at_lock, obs[0].er);
    end
  endtask

  task automatic test_en_drop();
    int pv_seen = 0;
    for (int i = 0; i < 10; i++) begin
      step({1'b0, (i % 2 == 0)}, 2'b00, 2'b00);
      checks++;
      if (obs[0] !== exp_o[0]) begin
        errors++;
        $display("FAIL en_drop step %0d: got %s, want %s", t, fmt(obs[0]), fmt(exp_o[0]));
      end
      if (obs[0].pv) pv_seen++;
      if (i == 0) begin
        checks++;
        if (obs[0].lk !== 1'b0) begin
          errors++;
          $display("FAIL en_drop_unlock: lk=%b want 0", obs[0].lk);
        end
      end
    end
    checks++;
    if (pv_seen !== 0 || obs[0].per !== 8'd2 || obs[0].hi !== 8'd1) begin
      errors++;
      $display("FAIL en_drop_hold: pulses=%0d %s, want 0 pulses period=2 high=1", pv_seen, fmt(obs[0]));
    end
  endtask

  task automatic test_ratio();
    int locked_seen = 0;
    for (int p = 0; p < 7; p++) begin
      for (int i = 0; i < 4; i++) begin
        step({(i == 0), 1'b0}, 2'b10, 2'b00);
        checks++;
        if (obs[1] !== exp_o[1]) begin
          errors++;
          $display("FAIL ratio_1_3 step %0d: got %s, want %s", t, fmt(obs[1]), fmt(exp_o[1]));
        end
      end
    end
    checks++;
    if ({obs[1].per, obs[1].hi, obs[1].lk, obs[1].er} !== {8'd4, 8'd1, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL ratio_lock: got %s, want period=4 high=1 lk=1 err=0", fmt(obs[1]));
    end
    step(2'b00, 2'b00, 2'b00);
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 5; i++) begin
        step({(i < 2), 1'b0}, 2'b10, 2'b00);
        checks++;
        if (obs[1] !== exp_o[1]) begin
          errors++;
          $display("FAIL ratio_2_3 step %0d: got %s, want %s", t, fmt(obs[1]), fmt(exp_o[1]));
        end
        if (obs[1].lk) locked_seen++;
      end
    end
    checks++;
    if ({obs[1].per, obs[1].hi, obs[1].er} !== {8'd5, 8'd2, 1'b0} || locked_seen !== 0) begin
      errors++;
      $display("FAIL ratio_nolock: got %s locked_cycles=%0d, want period=5 high=2 err=0 never locked",
               fmt(obs[1]), locked_seen);
    end
  endtask

  task automatic test_async_reset();
    int pv_seen = 0;
    int pv_at_lock = -1;
    for (int i = 0; i < 7; i++) step({1'b0, (i % 2 == 0)}, 2'b11, 2'b00);
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (obs[k] !== out_t'(0)) begin
        errors++;
        $display("FAIL async_reset dut%0d: got %s, want all zero", k, fmt(obs[k]));
      end
      mode[k]  = 0;
      good[k]  = 0;
      exp_o[k] = '0;
    end
    rst_t = t;
    #1 rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      step({1'b0, (i % 2 == 0)}, 2'b01, 2'b00);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_o[k]) begin
          errors++;
          $display("FAIL post_reset dut%0d step %0d: got %s, want %s", k, t, fmt(obs[k]), fmt(exp_o[k]));
        end
      end
      if (obs[0].pv) pv_seen++;
      if (obs[0].lk && pv_at_lock < 0) pv_at_lock = pv_seen;
    end
    checks++;
    if (pv_at_lock !== 4 || obs[0].er !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_lock: pulses before lock=%0d err=%b want 4 and 0", pv_at_lock, obs[0].er);
    end
  endtask

  task automatic test_err_clr_race();
    logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) step({1'b0, (i % 2 == 0)}, 2'b01, 2'b00);
    checks++;
    if (obs[0].lk !== 1'b1) begin
      errors++;
      $display("FAIL race_pre: lk=%b want 1", obs[0].lk);
    end
    // The stretched edge driven at pat[3] reaches the detector two cycles later.
    for (int i = 0; i < 6; i++) begin
      step({1'b0, pat[i]}, 2'b01, {1'b0, (i == 5)});
      checks++;
      if (obs[0] !== exp_o[0]) begin
        errors++;
        $display("FAIL race step %0d: got %s, want %s", t, fmt(obs[0]), fmt(exp_o[0]));
      end
    end
    checks++;
    if ({obs[0].pv, obs[0].per, obs[0].er} !== {1'b1, 8'd3, 1'b1}) begin
      errors++;
      $display("FAIL race_set_wins: got %s, want pv=1 period=3 err=1", fmt(obs[0]));
    end
    step(2'b00, 2'b01, 2'b01);
    checks++;
    if (obs[0].er !== 1'b0) begin
      errors++;
      $display("FAIL race_clear: err=%b want 0", obs[0].er);
    end
  endtask

  task automatic test_random();
    int   run [2] = '{0, 0};
    logic lvl [2] = '{1'b0, 1'b0};
    logic [1:0] c, e, x;
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (run[k] == 0) begin
          lvl[k] = ~lvl[k];
          if ($urandom_range(0, 299) == 0)
            run[k] = 260;
          else if ($urandom_range(0, 9) < 7)
            run[k] = (k == 1 && !lvl[k]) ? 3 : 1;
          else
            run[k] = int'($urandom_range(1, 5));
        end
        run[k]--;
        c[k] = lvl[k];
        e[k] = ($urandom_range(0, 199) != 0);
        x[k] = ($urandom_range(0, 39) == 0);
      end
      step(c, e, x);
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (obs[k] !== exp_o[k]) begin
          errors++;
          $display("FAIL random dut%0d step %0d: got %s, want %s", k, t, fmt(obs[k]), fmt(exp_o[k]));
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mode[k] = 0;
      good[k] = 0;
      last_rise[k] = 0;
      exp_o[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rst_t = t;
    test_reset();
    test_lock();
    test_stretch();
    test_timeout();
    test_en_drop();
    test_ratio();
    test_async_reset();
    test_err_clr_race();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
